mine_placer: RTL and testbench

Generates the mine map consumed by the click-evaluation logic. On a start request it clears the board arrays and places a fixed number of mines for the selected level at pseudo-random cells, using a seeded 16-bit LFSR. The cell under the player's first click is never mined. Its three array outputs drive the easy/medium/hard board inputs of the cell checker directly. `done` tells the game controller that the board is valid.

---
 rtl/mine_placer.sv | 93 +++++++++
 tb/tb_mine_placer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mine_placer.sv
// mine_placer: clears the board maps and places level-dependent mines from a seeded LFSR, sparing the first-click cell
module mine_placer #(
   parameter int MINES_EASY   = 10,
   parameter int MINES_MEDIUM = 20,
   parameter int MINES_HARD   = 40
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  level,
   input  logic [15:0] seed,
   input  logic [4:0]  safe_x,
   input  logic [4:0]  safe_y,
   output logic        array_easy   [7:0][7:0],
   output logic        array_medium [9:0][9:0],
   output logic        array_hard   [15:0][15:0],
   output logic        busy,
   output logic        done
);
   typedef enum logic [1:0] {IDLE, CLEAR, PLACE, DONE} state_t;
   state_t      r_state, w_next;
   logic [1:0]  r_lvl;
   logic [4:0]  r_sx, r_sy;
   logic [15:0] r_lfsr;
   logic [5:0]  r_cnt;
   logic        w_hard, w_med, w_fb, w_hit, w_range, w_safe, w_accept, w_last, w_load;
   logic [3:0]  w_x, w_y;
   logic [5:0]  w_need;
   // candidate cell from the pre-shift LFSR value and its accept/reject decision
   always_comb begin
      w_hard   = r_lvl == 2'd3;
      w_med    = r_lvl == 2'd2;
      w_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
      w_x      = (w_hard || w_med) ? r_lfsr[3:0] : {1'b0, r_lfsr[2:0]};
      w_y      = (w_hard || w_med) ? r_lfsr[7:4] : {1'b0, r_lfsr[6:4]};
      w_range  = !w_med || (w_x < 4'd10 && w_y < 4'd10);
      w_hit    = w_hard ? array_hard[w_y][w_x] : w_med ? (w_range && array_medium[w_y][w_x]) : array_easy[w_y[2:0]][w_x[2:0]];
      w_safe   = {1'b0, w_x} == r_sx && {1'b0, w_y} == r_sy;
      w_need   = w_hard ? 6'(MINES_HARD) : w_med ? 6'(MINES_MEDIUM) : 6'(MINES_EASY);
      w_accept = r_state == PLACE && w_range && !w_hit && !w_safe;
      w_last   = w_accept && r_cnt + 6'd1 == w_need;
   end
   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else r_state <= w_next;
   end
   // next-state and status outputs
   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      if ((r_state == IDLE || r_state == DONE) && start) begin
         w_next = CLEAR;
         w_load = 1'b1;
      end else if (r_state == CLEAR) w_next = PLACE;
      else if (w_last) w_next = DONE;
      busy = r_state == CLEAR || r_state == PLACE;
      done = r_state == DONE;
   end
   // request latch, LFSR stepping, board clearing and mine placement
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lvl        <= 2'd0;
         r_sx         <= 5'd0;
         r_sy         <= 5'd0;
         r_lfsr       <= 16'hACE1;
         r_cnt        <= 6'd0;
         array_easy   <= '{default: '0};
         array_medium <= '{default: '0};
         array_hard   <= '{default: '0};
      end else begin
         if (w_load) begin
            r_lvl  <= level;
            r_sx   <= safe_x;
            r_sy   <= safe_y;
            r_lfsr <= seed == 16'd0 ? 16'hACE1 : seed;
         end
         if (r_state == CLEAR) begin
            r_cnt        <= 6'd0;
            array_easy   <= '{default: '0};
            array_medium <= '{default: '0};
            array_hard   <= '{default: '0};
         end
         if (r_state == PLACE) r_lfsr <= {r_lfsr[14:0], w_fb};
         if (w_accept) begin
            r_cnt <= r_cnt + 6'd1;
            if (w_hard) array_hard[w_y][w_x] <= 1'b1;
            else if (w_med) array_medium[w_y][w_x] <= 1'b1;
            else array_easy[w_y[2:0]][w_x[2:0]] <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mine_placer.sv
// tb_mine_placer: per-cycle model comparison plus directed literal checks for mine_placer
module tb_mine_placer;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [1:0]  level = 2'd0;
   logic [15:0] seed = 16'd0;
   logic [4:0]  safe_x = 5'd0, safe_y = 5'd0;
   logic        array_easy [7:0][7:0];
   logic        array_medium [9:0][9:0];
   logic        array_hard [15:0][15:0];
   logic        busy, done;
   int n_chk = 0, n_fail = 0;
   int e = 0, m_t = 0, m_jf = 0, m_lv = 0, lat = 0;
   bit m_on = 1'b0;
   int m_idx [16][16];

   mine_placer dut (.clk(clk), .rst(rst), .start(start), .level(level), .seed(seed),
      .safe_x(safe_x), .safe_y(safe_y), .array_easy(array_easy), .array_medium(array_medium),
      .array_hard(array_hard), .busy(busy), .done(done));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, e);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   // Fills m_idx with the candidate index at which each cell gets its mine; returns index of the last mine.
   function automatic int gen(input logic [15:0] sd, input int lv, input int sx, input int sy);
      logic [15:0] l;
      int cnt, x, y, n;
      l = sd == 16'd0 ? 16'hACE1 : sd;
      n = lv == 2 ? 40 : lv == 1 ? 20 : 10;
      cnt = 0;
      for (int yy = 0; yy < 16; yy++) for (int xx = 0; xx < 16; xx++) m_idx[yy][xx] = -1;
      for (int j = 0; j < 200000; j++) begin
         x = lv == 0 ? int'(l[2:0]) : int'(l[3:0]);
         y = lv == 0 ? int'(l[6:4]) : int'(l[7:4]);
         if ((lv != 1 || (x < 10 && y < 10)) && m_idx[y][x] < 0 && !(x == sx && y == sy)) begin
            m_idx[y][x] = j;
            cnt++;
            if (cnt == n) return j;
         end
         l = lfsr_next(l);
      end
      return -1;
   endfunction

   function automatic int pop_easy();
      int c = 0;
      for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) c += int'(array_easy[y][x]);
      return c;
   endfunction
   function automatic int pop_med();
      int c = 0;
      for (int y = 0; y < 10; y++) for (int x = 0; x < 10; x++) c += int'(array_medium[y][x]);
      return c;
   endfunction
   function automatic int pop_hard();
      int c = 0;
      for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) c += int'(array_hard[y][x]);
      return c;
   endfunction

   // model: tracks accepted requests at each clock edge
   always @(posedge clk) begin
      bit mbusy;
      mbusy = m_on && (e - m_t) <= m_jf + 1;
      e++;
      if (rst) begin
         m_on = 1'b0;
         for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) m_idx[y][x] = -1;
      end else if (start && !mbusy) begin
         m_on = 1'b1;
         m_t  = e;
         m_lv = level == 2'd3 ? 2 : level == 2'd2 ? 1 : 0;
         m_jf = gen(seed, m_lv, int'(safe_x), int'(safe_y));
      end
   end

   // compare: DUT outputs against the model on every cycle after the first edge
   always @(negedge clk) if (e > 0) begin
      int d, me, mm, mh;
      bit b;
      d = e - m_t;
      chk("busy", int'(busy), int'(m_on && d <= m_jf + 1));
      chk("done", int'(done), int'(m_on && d > m_jf + 1));
      if (!(m_on && d == 0)) begin
         me = 0; mm = 0; mh = 0;
         for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) begin
            b = m_idx[y][x] >= 0 && (!m_on || m_idx[y][x] <= d - 2);
            if (y < 8 && x < 8) me += int'(array_easy[y][x] != (b && m_lv == 0));
            if (y < 10 && x < 10) mm += int'(array_medium[y][x] != (b && m_lv == 1));
            mh += int'(array_hard[y][x] != (b && m_lv == 2));
         end
         chk("easy_map_mismatches", me, 0);
         chk("medium_map_mismatches", mm, 0);
         chk("hard_map_mismatches", mh, 0);
      end
   end

   task automatic pulse(input logic [1:0] lv, input logic [15:0] sd, input logic [4:0] sx, input logic [4:0] sy);
      @(negedge clk);
      level = lv; seed = sd; safe_x = sx; safe_y = sy; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int l);
      l = 0;
      while (busy && l < 3000) begin
         l++;
         @(negedge clk);
      end
      chk("done_timeout", int'(busy), 0);
      chk("done_high", int'(done), 1);
   endtask

   initial begin
      chk("lfsr_pin0", int'(lfsr_next(16'hACE1)), 16'h59C3);
      chk("lfsr_pin1", int'(lfsr_next(16'h59C3)), 16'hB387);
      start = 1'b1; level = 2'd3; seed = 16'h7777;
      repeat (2) @(negedge clk);
      start = 1'b0; rst = 1'b0;
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_pop", pop_easy() + pop_med() + pop_hard(), 0);
      repeat (2) @(negedge clk);
      chk("idle_after_start_in_reset", int'(busy), 0);

      pulse(2'd1, 16'h1234, 5'd3, 5'd4);
      wait_done(lat);
      chk("easy_latency", lat, m_jf + 2);
      chk("easy_pop", pop_easy(), 10);
      chk("easy_safe", int'(array_easy[4][3]), 0);
      chk("easy_first_mine", int'(array_easy[3][4]), 1);
      chk("easy_second_mine", int'(array_easy[6][1]), 1);
      chk("easy_other_pop", pop_med() + pop_hard(), 0);

      pulse(2'd2, 16'hBEEF, 5'd2, 5'd3);
      wait_done(lat);
      chk("medium_pop", pop_med(), 20);
      chk("medium_safe", int'(array_medium[3][2]), 0);
      chk("medium_other_pop", pop_easy() + pop_hard(), 0);

      pulse(2'd3, 16'h0F0F, 5'd7, 5'd9);
      wait_done(lat);
      chk("hard_pop", pop_hard(), 40);
      chk("hard_safe", int'(array_hard[9][7]), 0);
      chk("hard_other_pop", pop_easy() + pop_med(), 0);

      pulse(2'd1, 16'h1234, 5'd3, 5'd4);
      repeat (4) @(negedge clk);
      pulse(2'd3, 16'h5555, 5'd0, 5'd0);
      wait_done(lat);
      chk("lockout_easy_pop", pop_easy(), 10);
      chk("lockout_hard_pop", pop_hard(), 0);
      chk("lockout_first_mine", int'(array_easy[3][4]), 1);

      pulse(2'd1, 16'h1234, 5'd3, 5'd4);
      wait_done(lat);
      chk("rerun_latency", lat, m_jf + 2);
      chk("rerun_pop", pop_easy(), 10);

      pulse(2'd0, 16'h0000, 5'd0, 5'd0);
      lat = 0;
      while (pop_easy() != 5 && lat < 3000) begin
         lat++;
         @(negedge clk);
      end
      chk("midplace_reached_5", pop_easy(), 5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midplace_reset_pop", pop_easy(), 0);
      chk("midplace_reset_busy", int'(busy), 0);

      pulse(2'd0, 16'h0000, 5'd0, 5'd0);
      wait_done(lat);
      chk("seed0_latency", lat, gen(16'hACE1, 0, 0, 0) + 2);
      chk("seed0_first_mine", int'(array_easy[6][1]), 1);
      chk("seed0_pop", pop_easy(), 10);

      pulse(2'd3, 16'hACE1, 5'd20, 5'd1);
      wait_done(lat);
      chk("oob_safe_pop", pop_hard(), 40);
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
